// File: rtl/pc_pkg.sv
// Shared constants and helpers for the PC target unit and its return-address stack.
package pc_pkg;

  localparam int unsigned INSTR_LEN        = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Low target bits that must be zero for a legal fetch address.
  function automatic logic [1:0] alignMask(input bit cExt);
    return cExt ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: top pointer plus a count that saturates at depth.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] pushData,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  entries [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptrInc;
  logic [PTR_W-1:0] ptrDec;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  assign ptrInc = ptr + PTR_W'(1);
  assign ptrDec = ptr - PTR_W'(1);
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(RAS_DEPTH));

  // Push+pop on an empty stack degenerates to a plain push.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) entries[PTR_W'(i)] <= '0;
    end else if (en) begin
      if (push && (!pop || empty)) begin
        entries[ptrInc] <= pushData;
        ptr             <= ptrInc;
        if (!full) count <= count + CNT_W'(1);
      end else if (push && pop) begin
        entries[ptr] <= pushData;
      end else if (pop && !empty) begin
        ptr   <= ptrDec;
        count <= count - CNT_W'(1);
      end
    end
  end

  assign valid = !empty;
  assign top   = empty ? '0 : entries[ptr];

endmodule

// File: rtl/pc_target_unit.sv
// Architectural PC register, branch/jump target adder, misalignment trap and RAS.
module pc_target_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     RAS_DEPTH = 4,
  parameter bit              C_EXT     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            take,
  input  logic            base_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] target,
  output logic            trap,
  output logic [XLEN-1:0] trap_addr,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);

  logic [XLEN-1:0] sum;
  logic            mis;
  logic            trapHit;
  logic            rasEn;

  assign pc_plus4 = pc + XLEN'(INSTR_LEN);
  assign sum      = (base_sel ? rs1 : pc) + imm;
  assign target   = base_sel ? {sum[XLEN-1:1], 1'b0} : sum;
  assign mis      = |(target[1:0] & alignMask(C_EXT));
  assign trapHit  = take && mis;
  assign rasEn    = !stall && !trapHit;

  // A stalled redirect is dropped entirely, including any trap it would raise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      trap      <= 1'b0;
      trap_addr <= '0;
    end else if (stall) begin
      trap <= 1'b0;
    end else if (trapHit) begin
      trap      <= 1'b1;
      trap_addr <= target;
    end else begin
      trap <= 1'b0;
      pc   <= take ? target : pc_plus4;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) uRas (
    .clk      (clk),
    .rst      (rst),
    .en       (rasEn),
    .push     (ras_push),
    .pop      (ras_pop),
    .pushData (pc_plus4),
    .top      (ras_top),
    .valid    (ras_valid)
  );

endmodule

// File: tb/tb_pc_target_unit.sv
// Directed and random checks of two pc_target_unit instances (4-byte and 2-byte alignment).
module tb_pc_target_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, stall, take, baseSel, rasPush, rasPop;
  logic [31:0] rs1, imm;

  logic [31:0] pcO [2];
  logic [31:0] pcP4O [2];
  logic [31:0] targetO [2];
  logic        trapO [2];
  logic [31:0] trapAddrO [2];
  logic [31:0] rasTopO [2];
  logic        rasValidO [2];

  int checks = 0;
  int errors = 0;

  // Reference state: the RAS is an ordered list, newest entry last.
  logic [31:0] mPc [2];
  logic [31:0] mTrapAddr [2];
  logic        mTrap [2];
  logic [31:0] mList [2][DEPTH];
  int          mCnt [2];

  always #5 clk = ~clk;

  pc_target_unit #(.XLEN(32), .RESET_PC(32'h100), .RAS_DEPTH(DEPTH), .C_EXT(1'b0)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .take(take), .base_sel(baseSel),
    .rs1(rs1), .imm(imm), .ras_push(rasPush), .ras_pop(rasPop),
    .pc(pcO[0]), .pc_plus4(pcP4O[0]), .target(targetO[0]), .trap(trapO[0]),
    .trap_addr(trapAddrO[0]), .ras_top(rasTopO[0]), .ras_valid(rasValidO[0]));

  pc_target_unit #(.XLEN(32), .RESET_PC(32'h100), .RAS_DEPTH(DEPTH), .C_EXT(1'b1)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .take(take), .base_sel(baseSel),
    .rs1(rs1), .imm(imm), .ras_push(rasPush), .ras_pop(rasPop),
    .pc(pcO[1]), .pc_plus4(pcP4O[1]), .target(targetO[1]), .trap(trapO[1]),
    .trap_addr(trapAddrO[1]), .ras_top(rasTopO[1]), .ras_valid(rasValidO[1]));

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelTarget(int i);
    logic [31:0] t;
    t = (baseSel ? rs1 : mPc[i]) + imm;
    if (baseSel) t = t & 32'hFFFF_FFFE;
    return t;
  endfunction

  // Instance 1 only needs halfword alignment.
  function automatic bit modelMis(int i, logic [31:0] t);
    return (i == 1) ? (t % 2 != 0) : (t % 4 != 0);
  endfunction

  function automatic logic [31:0] modelTop(int i);
    return (mCnt[i] == 0) ? 32'h0 : mList[i][mCnt[i]-1];
  endfunction

  task automatic modelPush(int i, logic [31:0] v);
    if (mCnt[i] == DEPTH) begin
      for (int j = 0; j < DEPTH - 1; j++) mList[i][j] = mList[i][j+1];
      mList[i][DEPTH-1] = v;
    end else begin
      mList[i][mCnt[i]] = v;
      mCnt[i]++;
    end
  endtask

  task automatic modelStep(int i);
    logic [31:0] t, ret;
    bit          m;
    t   = modelTarget(i);
    m   = modelMis(i, t);
    ret = mPc[i] + 32'd4;
    if (rst) begin
      mPc[i] = 32'h100; mTrap[i] = 1'b0; mTrapAddr[i] = 32'h0; mCnt[i] = 0;
      for (int j = 0; j < DEPTH; j++) mList[i][j] = 32'h0;
    end else if (stall) begin
      mTrap[i] = 1'b0;
    end else if (take && m) begin
      mTrap[i] = 1'b1; mTrapAddr[i] = t;
    end else begin
      mTrap[i] = 1'b0;
      mPc[i]   = take ? t : ret;
      if (rasPush && rasPop) begin
        if (mCnt[i] == 0) modelPush(i, ret);
        else mList[i][mCnt[i]-1] = ret;
      end else if (rasPush) begin
        modelPush(i, ret);
      end else if (rasPop && mCnt[i] > 0) begin
        mCnt[i]--;
      end
    end
  endtask

  // Inputs are already driven; compare everything, then advance one clock.
  task automatic runCycle(input bit doCheck);
    #1;
    if (doCheck) begin
      for (int i = 0; i < 2; i++) begin
        checkEq($sformatf("pc[%0d]", i), pcO[i], mPc[i]);
        checkEq($sformatf("pc_plus4[%0d]", i), pcP4O[i], mPc[i] + 32'd4);
        checkEq($sformatf("target[%0d]", i), targetO[i], modelTarget(i));
        checkEq($sformatf("trap[%0d]", i), 32'(trapO[i]), 32'(mTrap[i]));
        checkEq($sformatf("trap_addr[%0d]", i), trapAddrO[i], mTrapAddr[i]);
        checkEq($sformatf("ras_top[%0d]", i), rasTopO[i], modelTop(i));
        checkEq($sformatf("ras_valid[%0d]", i), 32'(rasValidO[i]), 32'(mCnt[i] != 0));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelStep(i);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; take = 0; baseSel = 0; rs1 = 0; imm = 0; rasPush = 0; rasPop = 0;
  endtask

  task automatic jumpTo(input logic [31:0] a, input bit push, input bit pop);
    idle(); take = 1; baseSel = 1; rs1 = a; rasPush = push; rasPop = pop;
    runCycle(1);
  endtask

  task automatic doReset();
    idle(); rst = 1; runCycle(1); idle();
  endtask

  initial begin
    idle(); rst = 1;
    runCycle(0);
    idle();
    checkEq("reset_pc", pcO[0], 32'h100);
    checkEq("reset_trap", 32'(trapO[0]), 32'h0);
    checkEq("reset_ras_valid", 32'(rasValidO[0]), 32'h0);
    checkEq("reset_ras_top", rasTopO[0], 32'h0);
    runCycle(1); checkEq("idle_pc1", pcO[0], 32'h104);
    runCycle(1); checkEq("idle_pc2", pcO[0], 32'h108);
    runCycle(1); checkEq("idle_pc3", pcO[0], 32'h10C);

    // Branch back by 16, then the same branch under stall.
    jumpTo(32'h200, 0, 0);
    idle(); take = 1; imm = 32'hFFFF_FFF0; runCycle(1);
    checkEq("branch_pc", pcO[0], 32'h1F0);
    jumpTo(32'h200, 0, 0);
    idle(); take = 1; imm = 32'hFFFF_FFF0; stall = 1; runCycle(1);
    checkEq("stall_branch_pc", pcO[0], 32'h200);

    // JALR to 0x1003: bit 0 cleared, bit 1 traps only under 4-byte alignment.
    idle(); take = 1; baseSel = 1; rs1 = 32'h1003; runCycle(1);
    checkEq("jalr_trap", 32'(trapO[0]), 32'h1);
    checkEq("jalr_trap_addr", trapAddrO[0], 32'h1002);
    checkEq("jalr_pc_held", pcO[0], 32'h200);
    checkEq("jalr_cext_pc", pcO[1], 32'h1002);
    checkEq("jalr_cext_trap", 32'(trapO[1]), 32'h0);
    idle(); runCycle(1);
    checkEq("trap_one_cycle", 32'(trapO[0]), 32'h0);
    checkEq("trap_addr_hold", trapAddrO[0], 32'h1002);

    // Five pushes overflow a four-entry stack, then five pops.
    doReset();
    jumpTo(32'h0, 0, 0);
    for (int k = 0; k < 5; k++) jumpTo(32'(16 * (k + 1)), 1, 0);
    checkEq("ras_full_top", rasTopO[0], 32'h44);
    idle(); rasPop = 1; runCycle(1); checkEq("ras_pop1", rasTopO[0], 32'h34);
    idle(); rasPop = 1; runCycle(1); checkEq("ras_pop2", rasTopO[0], 32'h24);
    idle(); rasPop = 1; runCycle(1); checkEq("ras_pop3", rasTopO[0], 32'h14);
    idle(); rasPop = 1; runCycle(1); checkEq("ras_pop4_valid", 32'(rasValidO[0]), 32'h0);
    idle(); rasPop = 1; runCycle(1);
    checkEq("ras_pop5_valid", 32'(rasValidO[0]), 32'h0);
    checkEq("ras_pop5_top", rasTopO[0], 32'h0);

    // Simultaneous push and pop: replace top; on empty it acts as a push.
    doReset();
    jumpTo(32'h30, 0, 0);
    jumpTo(32'h80, 1, 0);
    checkEq("pp_pre_top", rasTopO[0], 32'h34);
    idle(); rasPush = 1; rasPop = 1; runCycle(1);
    checkEq("pp_top", rasTopO[0], 32'h84);
    idle(); rasPop = 1; runCycle(1);
    checkEq("pp_count_kept", 32'(rasValidO[0]), 32'h0);
    jumpTo(32'h80, 0, 0);
    idle(); rasPush = 1; rasPop = 1; runCycle(1);
    checkEq("pp_empty_top", rasTopO[0], 32'h84);
    checkEq("pp_empty_valid", 32'(rasValidO[0]), 32'h1);

    // Reset collides with a redirect, a push and a pending trap.
    jumpTo(32'h1002, 0, 0);
    checkEq("pre_rst_trap", 32'(trapO[0]), 32'h1);
    idle(); rst = 1; take = 1; baseSel = 1; rs1 = 32'h1002; rasPush = 1; runCycle(1);
    checkEq("rst_pc", pcO[0], 32'h100);
    checkEq("rst_trap", 32'(trapO[0]), 32'h0);
    checkEq("rst_trap_addr", trapAddrO[0], 32'h0);
    checkEq("rst_ras_valid", 32'(rasValidO[0]), 32'h0);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(63) == 0);
      stall   = ($urandom_range(3) == 0);
      take    = ($urandom_range(2) == 0);
      baseSel = 1'($urandom_range(1));
      rs1     = $urandom;
      imm     = ($urandom_range(3) == 0) ? $urandom : (32'($urandom_range(64)) - 32'd32);
      rasPush = 1'($urandom_range(1));
      rasPop  = 1'($urandom_range(1));
      runCycle(1);
    end
    idle();
    runCycle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_target_unit.md
# pc_target_unit

Parametrised next-PC generator for the RISC-V core. Owns the architectural PC register and computes the branch/jump target with a selectable base: PC-relative for branches and JAL, register-relative for JALR. Detects misaligned targets and raises a registered trap. Adds a small return-address stack (RAS) that the fetch path uses for return prediction.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `RAS_DEPTH`, 4, RAS entries; power of two, ≥ 2.
- `C_EXT`, 0, 1 = 2-byte instruction alignment, 0 = 4-byte alignment.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hold PC and RAS this cycle.
- `take` in 1: redirect to `target` (taken branch or jump).
- `base_sel` in 1: 0 = base is `pc`, 1 = base is `rs1` (JALR).
- `rs1` in XLEN: register operand RD1.
- `imm` in XLEN: sign-extended immediate.
- `ras_push` in 1: push the return address (`pc_plus4`).
- `ras_pop` in 1: pop the top entry.
- `pc` out XLEN: current PC, registered.
- `pc_plus4` out XLEN: `pc + 4`, combinational.
- `target` out XLEN: computed target, combinational.
- `trap` out 1: one-cycle misaligned-target pulse, registered.
- `trap_addr` out XLEN: offending target, registered.
- `ras_top` out XLEN: top RAS entry (0 when empty).
- `ras_valid` out 1: RAS non-empty.

## Operation
- `target = (base_sel ? rs1 : pc) + imm`, computed modulo 2^XLEN. When `base_sel = 1`, bit 0 of the sum is forced to 0.
- `mis = C_EXT ? target[0] : |target[1:0]`, evaluated after the bit-0 clear.
- Next-PC priority:
  - `rst` loads `RESET_PC`.
  - Otherwise `stall` holds the PC.
  - Otherwise `take & mis` holds the PC, sets `trap = 1` and latches `trap_addr = target`.
  - Otherwise `take` loads `target`.
  - Otherwise the PC loads `pc_plus4`.
- `trap` is high for exactly one cycle per trapping redirect. `trap_addr` holds its value until the next trap or reset.
- RAS is a circular buffer with a top pointer and a count saturating at `RAS_DEPTH`. Updates occur only when `!stall && !(take & mis)`.
  - Push only: write `pc_plus4` at top+1, advance the pointer, increment count. When full, the oldest entry is overwritten and count stays at `RAS_DEPTH`.
  - Pop only: move the pointer back and decrement count. When empty, nothing changes.
  - Push and pop together: overwrite the top entry with `pc_plus4`; pointer and count are unchanged. When empty, this behaves as a push.
- `ras_valid = (count != 0)`. `ras_top` is the entry at the pointer when valid, else 0.

## Timing
- Reset values: `pc = RESET_PC`, `trap = 0`, `trap_addr = 0`, RAS count 0, pointer 0, all entries 0, `ras_valid = 0`, `ras_top = 0`.
- `target`, `pc_plus4` and the misalignment check settle combinationally in the same cycle as their inputs.
- `pc`, `trap` and the RAS update on the rising edge, with latency 1.
- `rst` asserted mid-operation overrides `stall`, `take` and the RAS controls on that edge. A pending trap is cleared.
- Stall plus take: the redirect is dropped. The pipeline re-presents `take` after the stall.
- Pointer wrap-around is modulo `RAS_DEPTH`. Width is `$clog2(RAS_DEPTH)`.

## Structure
- Shared package `pc_pkg` holds:
  - the instruction-length constant (4);
  - the alignment-mask function of `C_EXT`;
  - the default `RESET_PC`.
- Sub-module `ras_stack` (parameters `XLEN`, `RAS_DEPTH`) contains the circular buffer, pointer and count.
- The top level keeps the PC register, base mux, adder and trap logic.

## Test plan
- Reset with `RESET_PC = 32'h100`, then 3 idle cycles -> `pc` reads 0x100, 0x104, 0x108, 0x10C; `trap = 0`; `ras_valid = 0`.
- Branch at `pc = 0x200` with `take = 1`, `base_sel = 0`, `imm = -16` -> next `pc = 0x1F0`. Repeat with `stall = 1` -> `pc` stays 0x200.
- JALR with `rs1 = 0x1003`, `imm = 0`, `C_EXT = 0` -> target 0x1002 (bit 0 cleared). Bit 1 set gives `mis`: `trap` pulses once, `trap_addr = 0x1002`, `pc` held. Same case with `C_EXT = 1` -> `pc = 0x1002`, no trap.
- Five pushes into a `RAS_DEPTH = 4` stack at PCs 0x0/0x10/0x20/0x30/0x40, then five pops -> `ras_top` reads 0x44, 0x34, 0x24, 0x14, then `ras_valid = 0`. The fifth pop leaves the state unchanged.
- Push and pop together with top = 0x34, `pc = 0x80` -> top becomes 0x84 and count is unchanged. Same request while empty -> count becomes 1, top 0x84.
- Assert `rst` in the same cycle as `take`, `ras_push` and a pending trap -> `pc = RESET_PC`, `trap = 0`, RAS empty.
